// File: rtl/selecting_light_confirmed_fsm_if.sv
// Cell-level bundle for one seed-selection controller: neighbour cursor flags,
// player buttons and switches in, confirmed-seed flag out.
interface selecting_light_confirmed_fsm_if;
    logic l;
    logic a;
    logic r;
    logic b;
    logic leftButton;
    logic rightButton;
    logic upButton;
    logic downButton;
    logic confirmSeedSwitch;
    logic startGameSwitch;
    logic selectingLightConfirmed;

    modport master (
        output l, a, r, b,
        output leftButton, rightButton, upButton, downButton,
        output confirmSeedSwitch, startGameSwitch,
        input  selectingLightConfirmed
    );

    modport slave (
        input  l, a, r, b,
        input  leftButton, rightButton, upButton, downButton,
        input  confirmSeedSwitch, startGameSwitch,
        output selectingLightConfirmed
    );
endinterface

// File: rtl/selecting_light_confirmed_fsm.sv
// Per-cell setup controller: follows the selection cursor onto/off this cell
// and latches the cell as a live seed when confirmed; locks when the game starts.
module selecting_light_confirmed_fsm (
    input  logic                          clk,
    input  logic                          reset,
    selecting_light_confirmed_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        SEL_OFF,
        SEL_ON,
        CONF_SEED,
        CONF_NOT_SEED
    } state_e;

    state_e state_q, state_d;

    logic only_l, only_r, only_u, only_d;
    logic one_move, arrive;

    // A single pressed button is a move; any chord is treated as no move.
    assign only_l = bus.leftButton  & ~bus.rightButton & ~bus.upButton   & ~bus.downButton;
    assign only_r = bus.rightButton & ~bus.leftButton  & ~bus.upButton   & ~bus.downButton;
    assign only_u = bus.upButton    & ~bus.leftButton  & ~bus.rightButton & ~bus.downButton;
    assign only_d = bus.downButton  & ~bus.leftButton  & ~bus.rightButton & ~bus.upButton;

    assign one_move = only_l | only_r | only_u | only_d;
    assign arrive   = (only_l & bus.r) | (only_r & bus.l) |
                      (only_d & bus.a) | (only_u & bus.b);

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= SEL_OFF;
        else       state_q <= state_d;
    end

    // NOTE: state_d is defaulted first so no path through this block leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEL_OFF: begin
                if (bus.startGameSwitch) state_d = CONF_NOT_SEED;
                else if (arrive)         state_d = SEL_ON;
            end
            SEL_ON: begin
                if (bus.startGameSwitch)        state_d = CONF_NOT_SEED;
                else if (one_move)              state_d = SEL_OFF;
                else if (bus.confirmSeedSwitch) state_d = CONF_SEED;
            end
            CONF_SEED:     state_d = CONF_SEED;
            CONF_NOT_SEED: state_d = CONF_NOT_SEED;
            default:       state_d = SEL_OFF;
        endcase
    end

    assign bus.selectingLightConfirmed = (state_q == CONF_SEED);

endmodule

// File: tb/tb_selecting_light_confirmed_fsm.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a cursor/lock/seed reference model of the cell.
module tb_selecting_light_confirmed_fsm;

    typedef struct packed {
        logic rst;
        logic l, a, r, b;
        logic lb, rb, ub, db;
        logic conf, start;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Reference model: is the cursor here, has setup ended, is this a seed.
    bit m_here, m_locked, m_seed;

    selecting_light_confirmed_fsm_if bus ();

    selecting_light_confirmed_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void model_step(input stim_t s);
        int  n;
        bit  arrive;
        n      = int'(s.lb) + int'(s.rb) + int'(s.ub) + int'(s.db);
        arrive = (n == 1) && ((s.lb && s.r) || (s.rb && s.l) ||
                              (s.db && s.a) || (s.ub && s.b));
        if (s.rst) begin
            m_here = 0; m_locked = 0; m_seed = 0;
        end else if (!m_locked) begin
            if (s.start) begin
                m_locked = 1; m_here = 0;
            end else if (!m_here) begin
                if (arrive) m_here = 1;
            end else if (n == 1) begin
                m_here = 0;
            end else if (s.conf) begin
                m_locked = 1; m_seed = 1; m_here = 0;
            end
        end
    endfunction

    // Apply one cycle of stimulus, advance the model, compare after the edge.
    task automatic step(input stim_t s, input string name);
        reset                 = s.rst;
        bus.l                 = s.l;
        bus.a                 = s.a;
        bus.r                 = s.r;
        bus.b                 = s.b;
        bus.leftButton        = s.lb;
        bus.rightButton       = s.rb;
        bus.upButton          = s.ub;
        bus.downButton        = s.db;
        bus.confirmSeedSwitch = s.conf;
        bus.startGameSwitch   = s.start;
        @(posedge clk);
        model_step(s);
        #1;
        checks++;
        if (bus.selectingLightConfirmed !== logic'(m_seed)) begin
            errors++;
            $display("FAIL %s t=%0t confirmed=%b expected=%b", name, $time,
                     bus.selectingLightConfirmed, m_seed);
        end
    endtask

    function automatic stim_t idle();
        return '0;
    endfunction

    task automatic do_reset(input string name);
        stim_t s = idle();
        s.rst = 1;
        step(s, name);
    endtask

    task automatic select_via_left(input string name);
        stim_t s = idle();
        s.lb = 1; s.r = 1;
        step(s, name);
    endtask

    task automatic test_reset();
        do_reset("reset");
        for (int i = 0; i < 3; i++) step(idle(), "reset_hold");
    endtask

    task automatic test_confirm();
        stim_t s;
        do_reset("confirm_reset");
        select_via_left("confirm_select");
        s = idle(); s.conf = 1;
        step(s, "confirm_rise");
        s = idle(); s.l = 1; s.rb = 1;
        for (int i = 0; i < 4; i++) step(s, "confirm_hold");
        do_reset("confirm_clear");
    endtask

    task automatic test_simultaneous();
        stim_t s;
        do_reset("simul_reset");
        select_via_left("simul_select");
        s = idle(); s.conf = 1; s.start = 1;
        for (int i = 0; i < 4; i++) step(s, "simul_start_conf");
        s = idle(); s.conf = 1;
        step(s, "simul_locked");
    endtask

    task automatic test_start_while_selected();
        stim_t s;
        do_reset("start_reset");
        select_via_left("start_select");
        s = idle(); s.start = 1; s.r = 1; s.lb = 1;
        for (int i = 0; i < 4; i++) step(s, "start_locked");
        s = idle(); s.conf = 1;
        step(s, "start_no_confirm");
    endtask

    task automatic test_guards();
        stim_t s;
        do_reset("guard_reset");
        s = idle(); s.conf = 1;
        step(s, "guard_off_confirm");
        step(s, "guard_off_confirm2");
        s = idle(); s.lb = 1; s.rb = 1; s.l = 1; s.r = 1;
        step(s, "guard_chord");
        s = idle(); s.conf = 1;
        step(s, "guard_chord_confirm");
        s = idle(); s.ub = 1; s.b = 1;
        step(s, "guard_up_arrive");
        s = idle(); s.db = 1;
        step(s, "guard_down_leave");
        s = idle(); s.conf = 1;
        step(s, "guard_left_confirm");
        s = idle(); s.ub = 1; s.b = 1;
        step(s, "guard_up_again");
        s = idle(); s.lb = 1; s.conf = 1;
        step(s, "guard_move_beats_confirm");
        s = idle(); s.conf = 1;
        step(s, "guard_after_move");
        s = idle(); s.rb = 1; s.l = 1;
        step(s, "guard_right_arrive");
        s = idle(); s.conf = 1;
        step(s, "guard_right_confirm");
    endtask

    task automatic test_reset_mid();
        stim_t s;
        do_reset("mid_reset");
        select_via_left("mid_select");
        s = idle(); s.conf = 1;
        step(s, "mid_confirm");
        s = idle(); s.rst = 1; s.conf = 1; s.start = 1;
        step(s, "mid_reset_clears");
        s = idle(); s.conf = 1;
        step(s, "mid_sel_off");
    endtask

    task automatic test_random();
        stim_t s;
        do_reset("rand_reset");
        for (int i = 0; i < 3000; i++) begin
            s       = idle();
            s.rst   = ($urandom_range(63) == 0);
            s.l     = $urandom_range(1);
            s.a     = $urandom_range(1);
            s.r     = $urandom_range(1);
            s.b     = $urandom_range(1);
            s.lb    = ($urandom_range(3) == 0);
            s.rb    = ($urandom_range(3) == 0);
            s.ub    = ($urandom_range(3) == 0);
            s.db    = ($urandom_range(3) == 0);
            s.conf  = ($urandom_range(2) == 0);
            s.start = ($urandom_range(40) == 0);
            step(s, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.l = 0; bus.a = 0; bus.r = 0; bus.b = 0;
        bus.leftButton = 0; bus.rightButton = 0;
        bus.upButton = 0; bus.downButton = 0;
        bus.confirmSeedSwitch = 0; bus.startGameSwitch = 0;
        test_reset();
        test_confirm();
        test_simultaneous();
        test_start_while_selected();
        test_guards();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
